video_tile_scanout: RTL and testbench
=====================================

// Module: video_tile_scanout
// PURPOSE
//  Read side of the tile video memory that the CPU fills via WVM. Prefetches each 20-cell tile row
//  into a double-buffered line buffer during horizontal blanking, then streams 3-bit colour per pixel
//  in step with the VGA counters. Sits between VGA_Controller (counters/syncs) and the sprite overlay;
//  its output replaces the direct video-memory read path. Syncs are delayed to match pixel latency.
// PARAMETERS
//  H_VISIBLE   640  visible columns per line
//  V_VISIBLE   480  visible rows per frame
//  V_TOTAL     525  total rows per frame (last row index V_TOTAL-1 triggers frame prefetch)
//  TILES_X     20   tile cells fetched per tile row (TILE_W=32 px, fixed)
//  RD_LATENCY  1    video-memory read latency in cycles (1 or 2)
//  SYNC_IDLE   1    inactive level of oHorizontalSync/oVerticalSync
// PORTS
//  Clock            in   1   system clock
//  Reset            in   1   synchronous, active-high reset
//  iColumnCount     in   10  VGA column counter
//  iRowCount        in   10  VGA row counter
//  iHorizontalSync  in   1   raw hsync from VGA_Controller
//  iVerticalSync    in   1   raw vsync from VGA_Controller
//  oReadAddress     out  10  video-memory read address {tileRow[4:0], tileCol[4:0]}
//  iReadData        in   3   video-memory read data, valid RD_LATENCY cycles after address
//  oRGB             out  3   {R,G,B} pixel, registered
//  oHorizontalSync  out  1   hsync delayed 1 cycle (aligned to oRGB)
//  oVerticalSync    out  1   vsync delayed 1 cycle
//  oFetchBusy       out  1   high while FSM not IDLE
//  oUnderrun        out  1   1-cycle pulse: buffer swap occurred while fetch incomplete
// BEHAVIOUR
//  Reset: state IDLE; oReadAddress=0; oRGB=0; syncs=SYNC_IDLE; oFetchBusy=0; oUnderrun=0;
//   front-buffer select=0; both buffer-valid flags cleared (contents not cleared).
//  Fetch trigger (one cycle, iColumnCount==H_VISIBLE):
//   - iRowCount<V_VISIBLE-1 and iRowCount[3:0]==4'hF -> target tile row = (iRowCount+1)>>4.
//   - iRowCount==V_TOTAL-1 -> target tile row = 0.
//   - trigger while not IDLE: ignored (no restart).
//  FSM IDLE->FETCH on trigger; FETCH issues one address per cycle, col 0..TILES_X-1, row=target;
//   FETCH->DRAIN after col TILES_X-1 issued; DRAIN waits RD_LATENCY cycles for last data ->IDLE.
//   Data written to back buffer at index = col issued RD_LATENCY cycles earlier (address pipeline).
//   On DRAIN->IDLE: back-buffer valid flag set. Fetch takes TILES_X+RD_LATENCY cycles (<160 blank).
//  Swap: at iColumnCount==0 with iRowCount<V_VISIBLE and iRowCount[3:0]==0, front/back exchange;
//   new back buffer's valid flag cleared. If FSM not IDLE at swap: oUnderrun pulses, swap still
//   occurs, in-flight fetch continues into the (new) back buffer and is discarded at next swap.
//  Pixel path: visible = iColumnCount<H_VISIBLE && iRowCount<V_VISIBLE. oRGB(next) = visible &&
//   front valid ? front[iColumnCount[9:5]] : 3'b000. Latency 1 cycle, syncs delayed identically.
//  Column index >= TILES_X inside visible area cannot occur (640/32=20); no wrap handling required.
//  Tile row index wraps mod 32 (5 bits); rows 30/31 never fetched.
//  Simultaneous trigger and swap impossible (different columns); reset mid-fetch aborts to IDLE.
//  oReadAddress holds last value when IDLE.
// STRUCTURE
//  Timing/tile constants (TILE_W, TILE_H, TILES_X, H/V sizes) added to shared Defintions.v include.
//  FSM state encodings as local defines in this file.
//  Sub-module tile_line_buffer: 2 x 32 x 3-bit, one sync write port (bank, index, data),
//   one async read port (bank, index); bank select driven by front/back flag.
//  Top contains FSM, address counter, latency shift register, swap/valid logic, output regs.
// TESTING
//  1 Reset, memory cell {row0,col c}=c[2:0]; run to row 0 -> oRGB at col 32c+k = c[2:0], 1 cyc after counters.
//  2 Row 15 col 640 -> oFetchBusy high 21 cycles (RD_LATENCY=1), addresses 0x020..0x033 in order.
//  3 RD_LATENCY=2, memory returns addr-tagged data -> line buffer index i holds data of col i, none shifted.
//  4 Force fetch stall past col 0 of row 16 -> oUnderrun single pulse, row 16 pixels black (invalid).
//  5 Assert Reset mid-FETCH -> next cycle IDLE, oRGB=0, syncs=SYNC_IDLE, first frame black until row 524 fetch.
//  6 Columns 640..799 and rows 480..524 -> oRGB=000; hsync/vsync equal inputs delayed exactly 1 cycle.

Source files
------------

// File: rtl/video_tile_scanout_pkg.sv
// Shared types for the tile scanout: fetch FSM states and the read-address tag
// that travels alongside the video-memory latency.
package video_tile_scanout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic       live;
    logic [4:0] col;
  } rd_tag_t;

endpackage

// File: rtl/video_tile_scanout_line_buffer.sv
// Two 32-entry banks of 3-bit tile colours: synchronous write, asynchronous read.
module video_tile_scanout_line_buffer (
  input  logic       clk,
  input  logic       wr_en,
  input  logic       wr_bank,
  input  logic [4:0] wr_index,
  input  logic [2:0] wr_data,
  input  logic       rd_bank,
  input  logic [4:0] rd_index,
  output logic [2:0] rd_data
);

  logic [2:0] cells [2][32];

  always_ff @(posedge clk) begin
    if (wr_en) cells[wr_bank][wr_index] <= wr_data;
  end

  assign rd_data = cells[rd_bank][rd_index];

endmodule

// File: rtl/video_tile_scanout.sv
// Tile-row prefetch into a double-buffered line buffer during hblank, then
// per-pixel colour streaming with syncs delayed to match the 1-cycle pixel latency.
//
//  state    | meaning
//  ST_IDLE  | no fetch in flight, read address holds last value
//  ST_FETCH | issuing one tile-cell address per cycle, cols 0..TILES_X-1
//  ST_DRAIN | waiting RD_LATENCY cycles for the last read data to land
module video_tile_scanout
  import video_tile_scanout_pkg::*;
#(
  parameter int   H_VISIBLE  = 640,
  parameter int   V_VISIBLE  = 480,
  parameter int   V_TOTAL    = 525,
  parameter int   TILES_X    = 20,
  parameter int   RD_LATENCY = 1,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iColumnCount,
  input  logic [9:0] iRowCount,
  input  logic       iHorizontalSync,
  input  logic       iVerticalSync,
  output logic [9:0] oReadAddress,
  input  logic [2:0] iReadData,
  output logic [2:0] oRGB,
  output logic       oHorizontalSync,
  output logic       oVerticalSync,
  output logic       oFetchBusy,
  output logic       oUnderrun
);

  localparam int DRAIN_W = $clog2(RD_LATENCY + 1);

  fetch_state_t       state;
  logic [4:0]         tile_row;
  logic [4:0]         col_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               addr_live;
  rd_tag_t            tag_pipe [RD_LATENCY];
  logic               front_sel;
  logic [1:0]         buf_valid;

  logic       trig_line, trig_frame, trigger, swap_now, visible;
  logic       fetch_done, rd_bank, rd_valid;
  logic [4:0] target_row;
  logic [2:0] rd_data;

  assign trig_line  = (iRowCount < 10'(V_VISIBLE - 1)) && (iRowCount[3:0] == 4'hF);
  assign trig_frame = (iRowCount == 10'(V_TOTAL - 1));
  assign trigger    = (iColumnCount == 10'(H_VISIBLE)) && (trig_line || trig_frame);
  assign target_row = trig_frame ? 5'd0 : 5'((iRowCount + 10'd1) >> 4);
  assign swap_now   = (iColumnCount == 10'd0) && (iRowCount < 10'(V_VISIBLE)) &&
                      (iRowCount[3:0] == 4'h0);
  assign visible    = (iColumnCount < 10'(H_VISIBLE)) && (iRowCount < 10'(V_VISIBLE));
  assign fetch_done = (state == ST_DRAIN) && (drain_cnt == '0);

  // The first pixel of a tile row must already see the freshly swapped-in buffer.
  assign rd_bank  = swap_now ? ~front_sel : front_sel;
  assign rd_valid = buf_valid[rd_bank];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      oReadAddress <= '0;
      tile_row     <= '0;
      col_cnt      <= '0;
      drain_cnt    <= '0;
      addr_live    <= 1'b0;
      oFetchBusy   <= 1'b0;
    end else begin
      addr_live <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state        <= ST_FETCH;
            tile_row     <= target_row;
            oReadAddress <= {target_row, 5'd0};
            addr_live    <= 1'b1;
            col_cnt      <= 5'd1;
            oFetchBusy   <= 1'b1;
          end
        end
        ST_FETCH: begin
          oReadAddress <= {tile_row, col_cnt};
          addr_live    <= 1'b1;
          col_cnt      <= col_cnt + 5'd1;
          if (col_cnt == 5'(TILES_X - 1)) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_W'(RD_LATENCY);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state      <= ST_IDLE;
            oFetchBusy <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          oFetchBusy <= 1'b0;
        end
      endcase
    end
  end

  // Column tag follows each address so returning data lands at the right index.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= {addr_live, oReadAddress[4:0]};
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      front_sel <= 1'b0;
      buf_valid <= 2'b00;
      oUnderrun <= 1'b0;
    end else begin
      oUnderrun <= 1'b0;
      if (swap_now) begin
        front_sel            <= ~front_sel;
        buf_valid[front_sel] <= 1'b0;
        if (state != ST_IDLE) oUnderrun <= 1'b1;
      end
      if (fetch_done) buf_valid[~front_sel] <= 1'b1;
    end
  end

  video_tile_scanout_line_buffer u_line_buffer (
    .clk      (Clock),
    .wr_en    (tag_pipe[RD_LATENCY-1].live),
    .wr_bank  (~front_sel),
    .wr_index (tag_pipe[RD_LATENCY-1].col),
    .wr_data  (iReadData),
    .rd_bank  (rd_bank),
    .rd_index (iColumnCount[9:5]),
    .rd_data  (rd_data)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oRGB            <= 3'b000;
      oHorizontalSync <= SYNC_IDLE;
      oVerticalSync   <= SYNC_IDLE;
    end else begin
      oRGB            <= (visible && rd_valid) ? rd_data : 3'b000;
      oHorizontalSync <= iHorizontalSync;
      oVerticalSync   <= iVerticalSync;
    end
  end

endmodule

// File: tb/tb_video_tile_scanout.sv
// Bench for video_tile_scanout: two instances (read latency 1 and 2) driven by directed
// counter sequences, checked every cycle against a tile-level model plus literal spot checks.
module tb_video_tile_scanout;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] col, row;
  logic       hs, vs;

  logic [9:0] addr0, addr1;
  logic [2:0] rd0, rd1, rd1_a;
  logic [2:0] rgb0, rgb1;
  logic       hs0, hs1, vs0, vs1, busy0, busy1, und0, und1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  video_tile_scanout #(.RD_LATENCY(1)) dut0 (
    .Clock(clk), .Reset(rst), .iColumnCount(col), .iRowCount(row),
    .iHorizontalSync(hs), .iVerticalSync(vs), .oReadAddress(addr0), .iReadData(rd0),
    .oRGB(rgb0), .oHorizontalSync(hs0), .oVerticalSync(vs0), .oFetchBusy(busy0),
    .oUnderrun(und0)
  );

  video_tile_scanout #(.RD_LATENCY(2)) dut1 (
    .Clock(clk), .Reset(rst), .iColumnCount(col), .iRowCount(row),
    .iHorizontalSync(hs), .iVerticalSync(vs), .oReadAddress(addr1), .iReadData(rd1),
    .oRGB(rgb1), .oHorizontalSync(hs1), .oVerticalSync(vs1), .oFetchBusy(busy1),
    .oUnderrun(und1)
  );

  // Video memory contents: cell (tile row r, tile col c) holds (c + r) mod 8.
  function automatic logic [2:0] mem_val(input logic [9:0] a);
    return a[2:0] + a[7:5];
  endfunction

  always @(posedge clk) begin
    rd0   <= mem_val(addr0);
    rd1_a <= mem_val(addr1);
    rd1   <= rd1_a;
  end

  // Tile-level model: buffers hold a tile-row number (-1 invalid, -2 partially overwritten).
  int m_front [2];
  int m_back  [2];
  int f_k     [2];
  int f_row   [2];
  bit f_act   [2];
  bit f_dirty [2];
  int e_addr  [2];
  int e_rgb   [2];
  bit e_busy  [2];
  bit e_und   [2];
  bit e_known [2];
  bit e_hs, e_vs, m_vis;

  always @(posedge clk) begin
    m_vis = (int'(col) < 640) && (int'(row) < 480);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_front[d] = -1; m_back[d] = -1; f_act[d] = 1'b0; f_dirty[d] = 1'b0;
        e_addr[d] = 0; e_rgb[d] = 0; e_busy[d] = 1'b0; e_und[d] = 1'b0; e_known[d] = 1'b1;
      end else begin
        e_und[d] = 1'b0;
        if (col == 10'd0 && int'(row) < 480 && int'(row) % 16 == 0) begin
          if (f_act[d]) begin
            e_und[d] = 1'b1;
            f_dirty[d] = 1'b1;
          end
          m_front[d] = m_back[d];
          m_back[d] = -1;
        end
        if (f_act[d]) begin
          f_k[d]++;
          if (f_k[d] < 20) e_addr[d] = f_row[d] * 32 + f_k[d];
          if (f_k[d] == 20 + d + 1) begin
            f_act[d] = 1'b0;
            m_back[d] = f_dirty[d] ? -2 : f_row[d];
          end
        end else if (int'(col) == 640 &&
                     ((int'(row) < 479 && int'(row) % 16 == 15) || int'(row) == 524)) begin
          f_act[d] = 1'b1; f_k[d] = 0; f_dirty[d] = 1'b0;
          f_row[d] = (int'(row) == 524) ? 0 : ((int'(row) + 1) / 16) % 32;
          e_addr[d] = f_row[d] * 32;
        end
        e_busy[d] = f_act[d];
        e_known[d] = (m_front[d] != -2);
        e_rgb[d] = (m_vis && m_front[d] >= 0) ? (int'(col) / 32 + m_front[d]) % 8 : 0;
      end
    end
    e_hs = rst ? 1'b1 : hs;
    e_vs = rst ? 1'b1 : vs;
  end

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (col %0d row %0d, t=%0t)",
               name, d, act, exp, col, row, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [9:0] a, input logic [2:0] p,
                         input logic h, input logic v, input logic b, input logic u);
    check("addr", d, 32'(a), 32'(e_addr[d]));
    check("busy", d, 32'(b), 32'(e_busy[d]));
    check("underrun", d, 32'(u), 32'(e_und[d]));
    check("hsync", d, 32'(h), 32'(e_hs));
    check("vsync", d, 32'(v), 32'(e_vs));
    if (e_known[d]) check("rgb", d, 32'(p), 32'(e_rgb[d]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, addr0, rgb0, hs0, vs0, busy0, und0);
      cmp_dut(1, addr1, rgb1, hs1, vs1, busy1, und1);
    end
  end

  task automatic step(input int c, input int r);
    col = 10'(c);
    row = 10'(r);
    hs  = !(c >= 656 && c < 752);
    vs  = !(r == 490 || r == 491);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int r, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) step(c, r);
  endtask

  int nb0, nb1, nu0, nu1;

  initial begin
    rst = 1'b1; col = '0; row = '0; hs = 1'b1; vs = 1'b1;
    step(0, 0);
    step(700, 0);
    chk_en = 1'b1;
    check("reset_addr", 0, 32'(addr0), 32'd0);
    check("reset_rgb", 0, 32'(rgb0), 32'd0);
    check("reset_busy", 1, 32'(busy1), 32'd0);
    check("reset_hsync", 0, 32'(hs0), 32'd1);
    rst = 1'b0;

    // Frame prefetch of tile row 0, then row 0 pixels.
    run(524, 600, 799);
    run(0, 0, 99);
    step(100, 0);
    check("row0_col100", 0, 32'(rgb0), 32'd3);
    check("row0_col100", 1, 32'(rgb1), 32'd3);
    run(0, 101, 799);

    // Row 15 prefetch of tile row 1: busy length and address sequence.
    run(15, 600, 639);
    nb0 = 0; nb1 = 0;
    for (int c = 640; c <= 700; c++) begin
      step(c, 15);
      if (busy0) nb0++;
      if (busy1) nb1++;
      if (c == 640) begin
        check("first_addr", 0, 32'(addr0), 32'h020);
        check("first_addr", 1, 32'(addr1), 32'h020);
      end
      if (c == 659) begin
        check("last_addr", 0, 32'(addr0), 32'h033);
        check("last_addr", 1, 32'(addr1), 32'h033);
      end
    end
    check("busy_cycles", 0, 32'(nb0), 32'd21);
    check("busy_cycles", 1, 32'(nb1), 32'd22);
    run(15, 701, 799);
    run(16, 0, 99);
    step(100, 16);
    check("row16_col100", 0, 32'(rgb0), 32'd4);
    check("row16_col100", 1, 32'(rgb1), 32'd4);
    run(16, 101, 799);

    // Stalled fetch: jump to the swap line before it completes.
    run(31, 630, 645);
    nu0 = 0; nu1 = 0;
    for (int c = 0; c <= 700; c++) begin
      step(c, 32);
      if (und0) nu0++;
      if (und1) nu1++;
      if (c == 100) check("underrun_black", 0, 32'(rgb0), 32'd0);
    end
    check("underrun_pulses", 0, 32'(nu0), 32'd1);
    check("underrun_pulses", 1, 32'(nu1), 32'd1);

    // Reset in the middle of a fetch.
    run(47, 630, 659);
    rst = 1'b1;
    step(660, 47);
    check("midreset_busy", 0, 32'(busy0), 32'd0);
    check("midreset_hsync", 1, 32'(hs1), 32'd1);
    check("midreset_rgb", 0, 32'(rgb0), 32'd0);
    rst = 1'b0;
    run(47, 661, 799);
    run(0, 0, 799);
    run(490, 600, 799);
    run(524, 0, 799);
    run(0, 0, 120);
    check("refetch_col120", 0, 32'(rgb0), 32'd3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
